// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin values in 50-won units,
// hopper slot indices and the controller state encoding.
package change_dispenser_pkg;

    localparam logic [1:0] SLOT_50   = 2'd0;
    localparam logic [1:0] SLOT_100  = 2'd1;
    localparam logic [1:0] SLOT_500  = 2'd2;
    localparam logic [1:0] SLOT_1000 = 2'd3;

    localparam logic [4:0] VAL_50   = 5'd1;
    localparam logic [4:0] VAL_100  = 5'd2;
    localparam logic [4:0] VAL_500  = 5'd10;
    localparam logic [4:0] VAL_1000 = 5'd20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_DROP,
        ST_WAIT,
        ST_FIN
    } state_t;

    function automatic logic [4:0] coin_val(input logic [1:0] slot);
        case (slot)
            SLOT_50:   coin_val = VAL_50;
            SLOT_100:  coin_val = VAL_100;
            SLOT_500:  coin_val = VAL_500;
            default:   coin_val = VAL_1000;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_coin_selector.sv
// Greedy coin pick: the largest denomination that fits the remaining amount
// and still has stock in its hopper slot.
module coin_selector
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] i_remain,
    input  logic [3:0]       i_avail,
    output logic             o_valid,
    output logic [1:0]       o_slot
);

    localparam int CW = (AMT_W > 5) ? AMT_W : 5;

    logic [CW-1:0] w_rem;
    assign w_rem = CW'(i_remain);

    // Ascending scan: a later (larger) qualifying slot overrides a smaller one.
    always_comb begin
        o_valid = 1'b0;
        o_slot  = SLOT_50;
        for (int s = 0; s < 4; s++) begin
            if (i_avail[s] && (CW'(coin_val(2'(s))) <= w_rem)) begin
                o_valid = 1'b1;
                o_slot  = 2'(s);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser controller: greedy hopper sequencing with per-slot
// inventory, DropAck handshake and an acknowledge timeout.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W    = 8,
    parameter int CNT_W    = 6,
    parameter int INIT_CNT = 10,
    parameter int ACK_TMO  = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [AMT_W-1:0] Amount,
    input  logic             DropAck,
    input  logic             InvLoad,
    input  logic [1:0]       InvSel,
    input  logic [CNT_W-1:0] InvData,
    output logic             DROP50,
    output logic             DROP100,
    output logic             DROP500,
    output logic             DROP1000,
    output logic             Busy,
    output logic             Done,
    output logic             Short,
    output logic             Fault,
    output logic [AMT_W-1:0] Remain,
    output logic [3:0]       Empty
);

    localparam int TMO_W = $clog2(ACK_TMO + 1);

    state_t                  r_state, w_next;
    logic [3:0][CNT_W-1:0]   r_inv;
    logic [AMT_W-1:0]        r_remain;
    logic [1:0]              r_slot;
    logic [TMO_W-1:0]        r_tmo;
    logic                    r_short, r_fault;

    logic [3:0]              w_avail;
    logic                    w_sel_valid;
    logic [1:0]              w_sel_slot;
    logic                    w_tmo_hit;

    always_comb begin
        for (int s = 0; s < 4; s++) w_avail[s] = (r_inv[s] != '0);
    end

    coin_selector #(.AMT_W(AMT_W)) u_sel (
        .i_remain (r_remain),
        .i_avail  (w_avail),
        .o_valid  (w_sel_valid),
        .o_slot   (w_sel_slot)
    );

    // Last WAIT cycle before giving up; WAIT lasts at most ACK_TMO cycles.
    assign w_tmo_hit = (r_tmo == TMO_W'(ACK_TMO - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (Start && !InvLoad) w_next = ST_SEL;
            ST_SEL: begin
                if (r_remain == '0)   w_next = ST_FIN;
                else if (w_sel_valid) w_next = ST_DROP;
                else                  w_next = ST_FIN;
            end
            ST_DROP: w_next = ST_WAIT;
            ST_WAIT: begin
                if (DropAck)        w_next = ST_SEL;
                else if (w_tmo_hit) w_next = ST_FIN;
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_remain <= '0;
            r_slot   <= SLOT_50;
            r_tmo    <= '0;
            r_short  <= 1'b0;
            r_fault  <= 1'b0;
            for (int s = 0; s < 4; s++) r_inv[s] <= CNT_W'(INIT_CNT);
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (InvLoad) begin
                        r_inv[InvSel] <= InvData;
                    end else if (Start) begin
                        r_remain <= Amount;
                        r_short  <= 1'b0;
                        r_fault  <= 1'b0;
                    end
                end
                ST_SEL: begin
                    if (r_remain != '0) begin
                        if (w_sel_valid) r_slot  <= w_sel_slot;
                        else             r_short <= 1'b1;
                    end
                end
                ST_DROP: begin
                    r_inv[r_slot] <= r_inv[r_slot] - 1'b1;
                    r_remain      <= r_remain - AMT_W'(coin_val(r_slot));
                    r_tmo         <= '0;
                end
                ST_WAIT: begin
                    if (!DropAck) begin
                        if (w_tmo_hit) r_fault <= 1'b1;
                        else           r_tmo   <= r_tmo + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy     = (r_state != ST_IDLE);
    assign Done     = (r_state == ST_FIN);
    assign DROP50   = (r_state == ST_DROP) && (r_slot == SLOT_50);
    assign DROP100  = (r_state == ST_DROP) && (r_slot == SLOT_100);
    assign DROP500  = (r_state == ST_DROP) && (r_slot == SLOT_500);
    assign DROP1000 = (r_state == ST_DROP) && (r_slot == SLOT_1000);
    assign Short    = r_short;
    assign Fault    = r_fault;
    assign Remain   = r_remain;
    assign Empty    = ~w_avail;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes expected drop/done
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_change_dispenser;

    typedef struct {
        bit         is_done;
        logic [1:0] slot;
        bit         short_f;
        bit         fault_f;
        logic [7:0] remain;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] Amount = '0;
    logic       InvLoad = 1'b0;
    logic [1:0] InvSel = '0;
    logic [5:0] InvData = '0;
    logic       DROP50, DROP100, DROP500, DROP1000;
    logic       Busy, Done, Short, Fault;
    logic [7:0] Remain;
    logic [3:0] Empty;

    logic ack_auto = 1'b0;
    logic ack_force = 1'b0;
    logic ack_en = 1'b1;
    logic drop_n = 1'b0;
    logic ack_line;
    assign ack_line = ack_auto | ack_force;

    ev_t exp_q[$];
    int  n_chk = 0, n_pass = 0;
    int  cyc = 0, drop_cyc = 0, done_cyc = 0, done_cnt = 0, start_cyc = 0;

    change_dispenser dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Amount(Amount), .DropAck(ack_line),
        .InvLoad(InvLoad), .InvSel(InvSel), .InvData(InvData),
        .DROP50(DROP50), .DROP100(DROP100), .DROP500(DROP500), .DROP1000(DROP1000),
        .Busy(Busy), .Done(Done), .Short(Short), .Fault(Fault),
        .Remain(Remain), .Empty(Empty)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Hopper model: acknowledges on the first WAIT cycle after each drop.
    always @(negedge CLK) drop_n = DROP50 | DROP100 | DROP500 | DROP1000;
    always @(posedge CLK) begin
        #1;
        ack_auto = ack_en && drop_n;
    end

    always @(negedge CLK) begin
        logic [3:0] drops;
        ev_t e;
        drops = {DROP1000, DROP500, DROP100, DROP50};
        if (drops != 4'b0) begin
            chk($onehot(drops), "drop_onehot", int'(drops), 1);
            if (exp_q.size() == 0) chk(1'b0, "unexpected_drop", int'(drops), 0);
            else begin
                e = exp_q.pop_front();
                chk(!e.is_done && drops == (4'b1 << e.slot), "drop_slot",
                    int'(drops), e.is_done ? 0 : int'(4'b1 << e.slot));
            end
            drop_cyc = cyc;
        end
        if (Done) begin
            if (exp_q.size() == 0) chk(1'b0, "unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk(e.is_done, "done_kind", 1, int'(e.is_done));
                chk(Short == e.short_f, "done_short", int'(Short), int'(e.short_f));
                chk(Fault == e.fault_f, "done_fault", int'(Fault), int'(e.fault_f));
                chk(Remain == e.remain, "done_remain", int'(Remain), int'(e.remain));
            end
            done_cyc = cyc;
            done_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_drop(input logic [1:0] slot);
        ev_t e;
        e = '{is_done: 1'b0, slot: slot, short_f: 1'b0, fault_f: 1'b0, remain: 8'd0};
        exp_q.push_back(e);
    endtask

    task automatic push_done(input bit s, input bit f, input logic [7:0] rem);
        ev_t e;
        e = '{is_done: 1'b1, slot: 2'd0, short_f: s, fault_f: f, remain: rem};
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [1:0] sel, input logic [5:0] data);
        InvLoad = 1'b1; InvSel = sel; InvData = data;
        tick();
        InvLoad = 1'b0;
    endtask

    task automatic start_req(input logic [7:0] amt);
        Amount = amt; Start = 1'b1; start_cyc = cyc;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) chk(1'b0, name, 0, 1);
        tick();
    endtask

    initial begin
        repeat (3) tick();
        RST = 1'b0;
        tick();
        chk(Busy == 1'b0, "rst_busy", int'(Busy), 0);
        chk(Done == 1'b0, "rst_done", int'(Done), 0);
        chk(Short == 1'b0 && Fault == 1'b0, "rst_flags", int'({Short, Fault}), 0);
        chk(Remain == 8'd0, "rst_remain", int'(Remain), 0);
        chk(Empty == 4'b0, "rst_empty", int'(Empty), 0);

        // 33 units -> 1000, 500, 100, 50
        push_drop(2'd3); push_drop(2'd2); push_drop(2'd1); push_drop(2'd0);
        push_done(1'b0, 1'b0, 8'd0);
        start_req(8'd33);
        wait_done("t1_timeout");

        // Limited 100s: one 100 then two 50s
        load(2'd1, 6'd1);
        load(2'd0, 6'd5);
        push_drop(2'd1); push_drop(2'd0); push_drop(2'd0);
        push_done(1'b0, 1'b0, 8'd0);
        start_req(8'd4);
        wait_done("t2_timeout");
        chk(Empty == 4'b0010, "t2_empty", int'(Empty), 2);

        // No 50s: shortfall of one unit
        load(2'd0, 6'd0);
        load(2'd1, 6'd5);
        push_drop(2'd1);
        push_done(1'b1, 1'b0, 8'd1);
        start_req(8'd3);
        wait_done("t3_timeout");
        repeat (3) tick();
        chk(Short == 1'b1, "t3_short_hold", int'(Short), 1);
        chk(Remain == 8'd1, "t3_remain_hold", int'(Remain), 1);
        chk(Empty == 4'b0001, "t3_empty", int'(Empty), 1);

        // Missing DropAck -> fault after ACK_TMO WAIT cycles
        ack_en = 1'b0;
        push_drop(2'd1);
        push_done(1'b0, 1'b1, 8'd0);
        start_req(8'd2);
        wait_done("t4_timeout");
        chk(done_cyc - drop_cyc == 16, "t4_tmo_latency", done_cyc - drop_cyc, 16);
        chk(Fault == 1'b1, "t4_fault_hold", int'(Fault), 1);

        // Start and InvLoad during WAIT are ignored
        push_drop(2'd3);
        start_req(8'd20);
        repeat (4) tick();
        Amount = 8'd2; Start = 1'b1;
        tick();
        Start = 1'b0;
        load(2'd3, 6'd2);
        chk(Busy == 1'b1, "t5_busy_wait", int'(Busy), 1);
        push_done(1'b0, 1'b0, 8'd0);
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        ack_en = 1'b1;
        wait_done("t5a_timeout");
        chk(Fault == 1'b0, "t5_fault_clear", int'(Fault), 0);
        push_drop(2'd3); push_drop(2'd3); push_drop(2'd3);
        push_done(1'b0, 1'b0, 8'd0);
        start_req(8'd60);
        wait_done("t5b_timeout");
        load(2'd3, 6'd2);
        push_drop(2'd3); push_drop(2'd3); push_drop(2'd2); push_drop(2'd2);
        push_done(1'b0, 1'b0, 8'd0);
        start_req(8'd60);
        wait_done("t5c_timeout");
        chk(Empty == 4'b1001, "t5_empty", int'(Empty), 9);

        // InvLoad together with Start: load wins, request dropped
        InvLoad = 1'b1; InvSel = 2'd0; InvData = 6'd1; Amount = 8'd1; Start = 1'b1;
        tick();
        InvLoad = 1'b0; Start = 1'b0;
        tick();
        chk(Busy == 1'b0, "ld_start_busy", int'(Busy), 0);
        chk(Empty == 4'b1000, "ld_start_empty", int'(Empty), 8);
        push_drop(2'd0);
        push_done(1'b0, 1'b0, 8'd0);
        start_req(8'd1);
        wait_done("ld_start_timeout");

        // Reset in the middle of WAIT
        ack_en = 1'b0;
        push_drop(2'd1);
        start_req(8'd2);
        repeat (5) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk(Busy == 1'b0, "t6_busy", int'(Busy), 0);
        chk(Empty == 4'b0, "t6_empty", int'(Empty), 0);
        chk(Remain == 8'd0, "t6_remain", int'(Remain), 0);
        ack_en = 1'b1;
        repeat (20) tick();
        push_done(1'b0, 1'b0, 8'd0);
        start_req(8'd0);
        wait_done("t6_zero_timeout");
        chk(done_cyc - start_cyc == 2, "t6_zero_latency", done_cyc - start_cyc, 2);

        repeat (3) tick();
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
